// File: rtl/seq_mult4_pkg.sv
// seq_mult4_pkg
//   Shared definitions for the 4x4 sequential shift-add multiplier:
//   operand/product widths, iteration count, iteration counter width and
//   the controller state encoding.
package seq_mult4_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ITER_N = 4;
    localparam int CNT_W  = 2;

    // Counter value on the last shift-add iteration
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_N - 1);

    // 2-bit state encoding; 2'b11 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_mult4_car_look.sv
// car_look
//   4-bit carry-lookahead adder used for the partial-product add.
//   Ports:
//     a, b  [3:0]  addends
//     cin          carry in
//     sum   [4:0]  {carry out, 4-bit sum}
module car_look
    import seq_mult4_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    output logic [OP_W:0]   sum
);

    logic [OP_W-1:0] g_s;
    logic [OP_W-1:0] p_s;
    logic [OP_W:0]   c_s;

    // Generate/propagate terms and fully expanded lookahead carries
    always_comb begin
        g_s = a & b;
        p_s = a ^ b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum = {c_s[4], p_s ^ c_s[OP_W-1:0]};
    end

endmodule

// File: rtl/seq_mult4.sv
// seq_mult4
//   Unsigned 4x4 -> 8 sequential shift-add multiplier. One shift-add
//   iteration per clock for four clocks, then a one-cycle DONE state.
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     start          request, accepted only when idle
//     a, b    [3:0]  multiplicand / multiplier, captured on acceptance
//     busy           high while the iterations run
//     done           one-cycle completion pulse
//     product [7:0]  last result, held until the next result or reset
//   busy and done are registered decodes of the controller state, so they
//   trail it by one clock: with start accepted at edge N, busy is high after
//   edges N+1..N+4 and done after edge N+5. The earliest next acceptance
//   is edge N+6.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q,   state_d;
    logic [PROD_W-1:0]   acc_q,     acc_d;
    logic [OP_W-1:0]     mcand_q,   mcand_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic [OP_W:0]       sum_s;
    logic [OP_W:0]       add_sel_s;
    logic [PROD_W-1:0]   shift_s;

    car_look u_car_look (
        .a   (acc_q[PROD_W-1:OP_W]),
        .b   (mcand_q),
        .cin (1'b0),
        .sum (sum_s)
    );

    // Partial-product select and one-bit right shift of {add, lo}
    always_comb begin
        if (acc_q[0]) begin
            add_sel_s = sum_s;
        end else begin
            add_sel_s = {1'b0, acc_q[PROD_W-1:OP_W]};
        end
        // {add, lo} >> 1 keeps add (carry lands in bit 7) and drops lo[0]
        shift_s = {add_sel_s, acc_q[OP_W-1:1]};
    end

    // Next-state and datapath next-value logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{OP_W{1'b0}}, b};
                    count_d = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = shift_s;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    product_d = shift_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_q == ST_RUN);
        done_d = (state_q == ST_DONE);
    end

    // State and datapath registers; reset overrides any activity in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= {PROD_W{1'b0}};
            mcand_q   <= {OP_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            product_q <= {PROD_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult4.sv
// tb_seq_mult4
//   Self-checking bench for seq_mult4: reset state, a directed vector table,
//   random operands against a plain a*b model, start-ignored and
//   reset-abort sequences, and an exhaustive back-to-back sweep.
module tb_seq_mult4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int total;
    int bad;
    int done_cnt;
    int n_mult;
    logic [7:0] prod_model;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         poke;
    } vec_t;

    seq_mult4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses as seen just before each rising edge
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge. Launches one multiply, optionally re-asserts start
    // (with a=b=1) at negedge index 'poke', and checks the busy/done timeline,
    // product hold during the run, and the final product.
    task automatic do_mult(input logic [3:0] ta, input logic [3:0] tb,
                           input logic [7:0] texp, input int poke, input string nm);
        logic [5:0] busy_seen;
        logic [5:0] done_seen;
        a_i = ta;
        b_i = tb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_i = 4'($urandom);
        b_i = 4'($urandom);
        busy_seen[0] = busy;
        done_seen[0] = done;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            busy_seen[k] = busy;
            done_seen[k] = done;
            if (k <= 3) check({nm, ":hold"}, {24'd0, product}, {24'd0, prod_model});
            if (k == poke) begin
                start = 1'b1;
                a_i = 4'd1;
                b_i = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        check({nm, ":busy"}, {26'd0, busy_seen}, {26'd0, 6'b011110});
        check({nm, ":done"}, {26'd0, done_seen}, {26'd0, 6'b100000});
        check({nm, ":product"}, {24'd0, product}, {24'd0, texp});
        prod_model = texp;
        n_mult++;
    endtask

    vec_t vecs[8];

    initial begin
        int d0;
        logic [3:0] ra;
        logic [3:0] rb;
        total = 0;
        bad = 0;
        done_cnt = 0;
        n_mult = 0;
        prod_model = 8'h00;

        vecs[0] = '{4'd5,  4'd3,  8'h0F, -1};
        vecs[1] = '{4'd15, 4'd15, 8'hE1, -1};
        vecs[2] = '{4'd15, 4'd1,  8'h0F, -1};
        vecs[3] = '{4'd0,  4'd9,  8'h00, -1};
        vecs[4] = '{4'd10, 4'd6,  8'h3C, 2};
        vecs[5] = '{4'd9,  4'd0,  8'h00, 4};
        vecs[6] = '{4'd1,  4'd15, 8'h0F, 1};
        vecs[7] = '{4'd7,  4'd7,  8'h31, -1};

        rst = 1'b1;
        start = 1'b1;
        a_i = 4'd7;
        b_i = 4'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset:busy", {31'd0, busy}, 32'd0);
        check("reset:done", {31'd0, done}, 32'd0);
        check("reset:product", {24'd0, product}, 32'd0);

        // First start on the first edge with rst low
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_mult(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].poke, $sformatf("vec%0d", i));
        end

        // Idle with start low: nothing moves
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle:busy", {31'd0, busy}, 32'd0);
            check("idle:product", {24'd0, product}, {24'd0, prod_model});
        end

        // Random operands against plain arithmetic
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_mult(ra, rb, 8'(ra * rb), int'($urandom_range(0, 5)), "rand");
        end

        // Reset on the second RUN cycle abandons the multiply
        @(negedge clk);
        @(negedge clk);
        d0 = done_cnt;
        a_i = 4'd12;
        b_i = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prod_model = 8'h00;
        check("abort:busy", {31'd0, busy}, 32'd0);
        check("abort:product", {24'd0, product}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort:no_done", done_cnt - d0, 32'd0);
        check("abort:product_stays", {24'd0, product}, 32'd0);
        do_mult(4'd12, 4'd3, 8'h24, -1, "after_abort");

        // Exhaustive sweep, back-to-back at 6-cycle spacing
        @(negedge clk);
        @(negedge clk);
        d0 = done_cnt;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_mult(4'(x), 4'(y), 8'(x * y), -1, $sformatf("sweep_%0d_%0d", x, y));
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("sweep:done_count", done_cnt - d0, 32'd256);
        check("total:done_count", done_cnt, n_mult);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
